mul_controller: RTL and testbench
=================================

# mul_controller

Sequencing FSM for the repeated-addition multiplier datapath. It accepts operand A, then operand B, on the shared `data_in` bus through a valid/ready handshake. It drives the datapath strobes `ldA`, `ldB`, `clrP`, `ldP` and `decB`, and uses the datapath's `eqZ` (B == 1) to end the add loop. It also handles B == 0, guards the loop with an iteration watchdog, and holds `done` or `err` until the consumer acknowledges.

## Interface
- `WIDTH`, default 16: operand, bus and iteration-counter width.
- `MAX_ITER`, default 65535: watchdog limit on ADD cycles per operation.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: an operand is present on `data_in`.
- `data_in`  in  WIDTH: the operand bus, also wired to the datapath.
- `eqZ`  in  1: from the datapath, high when register B == 1.
- `abort`  in  1: synchronous abort of the current operation.
- `res_ack`  in  1: consumer has taken the result or error.
- `in_ready`  out  1: the controller will take the operand this cycle.
- `ldA`, `ldB`, `clrP`, `ldP`, `decB`  out  1 each: datapath strobes.
- `busy`  out  1: an operation is in progress (GET_B or ADD).
- `done`  out  1: the product in datapath register P is valid.
- `err`  out  1: the watchdog expired and P is invalid.
- `iter_cnt`  out  WIDTH: ADD cycles executed in the current or last operation.

## Operation
- States: IDLE, GET_B, ADD, DONE, ERR. The state register and `iter_cnt` reset asynchronously to IDLE and 0.
- While `rst` is high, every output is 0.
- All strobes are combinational decodes of state and inputs. Each strobe is high for exactly one cycle per event.
- IDLE:
  - `in_ready`=1.
  - If `in_valid` && !`abort`: `ldA`=1 and go to GET_B.
- GET_B:
  - `in_ready`=1, `busy`=1.
  - If `in_valid` && !`abort`: `ldB`=1, `clrP`=1, `iter_cnt`<=0.
  - Next state is DONE if `data_in`==0 (product 0, no adds). Otherwise next state is ADD.
- ADD:
  - `ldP`=1, `decB`=1, `busy`=1, and `iter_cnt` increments every cycle.
  - If `eqZ`: this is the final add, go to DONE.
  - Else if `iter_cnt`==MAX_ITER-1: go to ERR. No strobes are suppressed on that cycle.
- DONE:
  - `done`=1, and it holds until `res_ack`. Then go to IDLE.
- ERR:
  - `err`=1, and it holds until `res_ack`. Then go to IDLE.
- `abort` in GET_B, ADD, DONE or ERR:
  - Go to IDLE next cycle.
  - All strobes are forced to 0 that cycle.
  - `iter_cnt` keeps its value.
- `abort` in IDLE blocks operand acceptance.
- `abort` has priority over `in_valid`, `eqZ` and `res_ack`.
- In DONE, `in_valid` is ignored (`in_ready`=0). The next A is accepted no earlier than the cycle after the `res_ack` cycle.
- Arithmetic:
  - `iter_cnt` is unsigned and saturates at 2^WIDTH-1. It never wraps.
  - The product is P = A·B mod 2^WIDTH, computed by the datapath. The controller does not check for overflow.
- Strobe invariants:
  - `ldB` and `decB` are never high together.
  - `clrP` and `ldP` are never high together.
  - `ldA` is never high outside IDLE.

## Timing
- A accepted at edge t. B accepted at edge t' ≥ t+1.
- ADD occupies cycles t'+1 … t'+B, exactly B `ldP`/`decB` strobes.
- `done` rises in cycle t'+B+1. Total latency from B acceptance is B+1 cycles.
- B == 0: `done` rises in cycle t'+1, with P=0 from `clrP`.
- B == 1: one ADD cycle, because `eqZ` is already high on entry.
- Watchdog: ERR is entered after exactly MAX_ITER ADD cycles without `eqZ`.
- Minimum `done` pulse width is 1 cycle, when `res_ack` is already high on DONE entry.
- Asynchronous `rst` mid-operation: state goes to IDLE immediately. The datapath registers are not cleared; the next operation re-clears P via `clrP`.

## Test plan
- A=7, B=5: exactly 5 `ldP`/`decB` strobes; `done` rises 6 cycles after B is accepted; P=35; `iter_cnt`=5; after `res_ack`, `in_ready`=1 the next cycle.
- A=9, B=0: no `ldP` strobes; `done` rises 1 cycle after B is accepted; P=0; `iter_cnt`=0.
- A=300, B=300: `done` rises after 301 cycles; P=90000 mod 65536 = 24464.
- MAX_ITER=4, B=10: ERR after 4 ADD cycles; `err`=1, `done`=0; `err` holds until `res_ack`; then back to IDLE.
- `abort` on the 3rd ADD cycle of B=6: no strobes that cycle; IDLE next cycle; `iter_cnt`=2; a new A=2, B=3 then gives P=6.
- `rst` pulsed in the middle of ADD: all outputs 0 immediately; after release, `in_ready`=1; a new A=3, B=4 gives P=12.

Source files
------------

// File: rtl/mul_controller.sv
// Sequencing FSM for a repeated-addition multiplier: takes A then B over a shared
// valid/ready bus, strobes the datapath through the add loop and holds done/err until acked.
module mul_controller #(
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             eqZ,
  input  logic             abort,
  input  logic             res_ack,
  output logic             in_ready,
  output logic             ldA,
  output logic             ldB,
  output logic             clrP,
  output logic             ldP,
  output logic             decB,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] iter_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET_B = 3'd1,
    S_ADD   = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ITER_LIMIT = WIDTH'(MAX_ITER - 1);

  state_t state, state_nxt;
  logic   take_b;
  logic   add_step;

  // Handshake: an operand transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE/GET_B and drops while abort is asserted.
  assign take_b   = (state == S_GET_B) && in_valid && !abort;
  assign add_step = (state == S_ADD) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (in_valid) state_nxt = S_GET_B;
        S_GET_B: if (in_valid) state_nxt = (data_in == '0) ? S_DONE : S_ADD;
        S_ADD: begin
          if (eqZ)                        state_nxt = S_DONE;
          else if (iter_cnt == ITER_LIMIT) state_nxt = S_ERR;
        end
        S_DONE:  if (res_ack) state_nxt = S_IDLE;
        S_ERR:   if (res_ack) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // All outputs are held low while rst is asserted, not just after the edge.
  always_comb begin
    in_ready = 1'b0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    clrP     = 1'b0;
    ldP      = 1'b0;
    decB     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          in_ready = !abort;
          ldA      = in_valid && !abort;
        end
        S_GET_B: begin
          in_ready = !abort;
          busy     = 1'b1;
          ldB      = take_b;
          clrP     = take_b;
        end
        S_ADD: begin
          busy = 1'b1;
          ldP  = add_step;
          decB = add_step;
        end
        S_DONE:  done = 1'b1;
        S_ERR:   err  = 1'b1;
        default: ;
      endcase
    end
  end

  // Counts ADD cycles; saturates so a runaway loop can never look short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt <= '0;
    end else if (take_b) begin
      iter_cnt <= '0;
    end else if (add_step && (iter_cnt != '1)) begin
      iter_cnt <= iter_cnt + 1'b1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mul_controller.sv
// Directed bench for mul_controller with a behavioural datapath (A, B, P registers)
// closing the eqZ loop; a second instance with MAX_ITER=4 exercises the watchdog.
module tb_mul_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;

  logic        in_valid, abort, res_ack, eqZ;
  logic        in_ready, ldA, ldB, clrP, ldP, decB, busy, done, err;
  logic [15:0] iter_cnt;
  logic [2:0]  state_dbg;

  logic        in_valid_w, abort_w, res_ack_w, eqZ_w;
  logic        in_ready_w, ldA_w, ldB_w, clrP_w, ldP_w, decB_w, busy_w, done_w, err_w;
  logic [15:0] iter_cnt_w;
  logic [2:0]  state_dbg_w;

  logic [15:0] reg_a = '0, reg_b = '0, reg_p = '0;
  logic [15:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_controller #(.WIDTH(16), .MAX_ITER(65535)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .eqZ(eqZ),
    .abort(abort), .res_ack(res_ack), .in_ready(in_ready), .ldA(ldA), .ldB(ldB),
    .clrP(clrP), .ldP(ldP), .decB(decB), .busy(busy), .done(done), .err(err),
    .iter_cnt(iter_cnt), .state_dbg(state_dbg)
  );

  mul_controller #(.WIDTH(16), .MAX_ITER(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .data_in(data_in), .eqZ(eqZ_w),
    .abort(abort_w), .res_ack(res_ack_w), .in_ready(in_ready_w), .ldA(ldA_w), .ldB(ldB_w),
    .clrP(clrP_w), .ldP(ldP_w), .decB(decB_w), .busy(busy_w), .done(done_w), .err(err_w),
    .iter_cnt(iter_cnt_w), .state_dbg(state_dbg_w)
  );

  // Datapath model: not reset, matching the real datapath.
  always @(posedge clk) begin
    if (ldA) reg_a <= data_in;
    if (ldB) reg_b <= data_in;
    else if (decB) reg_b <= reg_b - 16'd1;
    if (clrP) reg_p <= '0;
    else if (ldP) reg_p <= reg_p + reg_a;
  end
  assign eqZ   = (reg_b == 16'd1);
  assign eqZ_w = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Strobe invariants on both instances every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((ldB && decB) || (clrP && ldP) || (ldA && state_dbg != 3'd0) ||
          (ldB_w && decB_w) || (clrP_w && ldP_w) || (ldA_w && state_dbg_w != 3'd0)) begin
        errors++;
        $display("FAIL strobe_invariant: got ldB=%0b decB=%0b clrP=%0b ldP=%0b ldA=%0b state=%0d expected no overlap",
                 ldB, decB, clrP, ldP, ldA, state_dbg);
      end
    end
  end

  // Sends A then B, waits for done, checks product, iter count, latency, strobe count.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_iter,
                        input int exp_lat);
    int  k;
    int  n_ldp;
    bit  seen;
    logic [15:0] exp_p;
    @(negedge clk);
    check("ready_a", in_ready, 1);
    data_in  = a;
    in_valid = 1'b1;
    @(negedge clk);
    check("ready_b", in_ready, 1);
    data_in = b;
    n_ldp = 0;
    seen  = 0;
    for (k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (done) begin
        seen = 1;
        break;
      end
      if (ldP) n_ldp++;
    end
    exp_p = exp_q.pop_front();
    check("done_seen", seen, 1);
    check("latency", k, exp_lat);
    check("ldp_count", n_ldp, {16'd0, b});
    check("product", reg_p, exp_p);
    check("iter_cnt", iter_cnt, exp_iter);
    check("busy_done", busy, 0);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check("ready_after_ack", in_ready, 1);
    check("done_after_ack", done, 0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic [15:0] iter;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k;
    int n_ldp;
    bit seen;

    vecs[0] = '{a: 16'd7,     b: 16'd5,   p: 16'd35,    iter: 16'd5,   lat: 6};
    vecs[1] = '{a: 16'd9,     b: 16'd0,   p: 16'd0,     iter: 16'd0,   lat: 1};
    vecs[2] = '{a: 16'd300,   b: 16'd300, p: 16'd24464, iter: 16'd300, lat: 301};
    vecs[3] = '{a: 16'd1,     b: 16'd1,   p: 16'd1,     iter: 16'd1,   lat: 2};
    vecs[4] = '{a: 16'd65535, b: 16'd2,   p: 16'd65534, iter: 16'd2,   lat: 3};
    vecs[5] = '{a: 16'd13,    b: 16'd11,  p: 16'd143,   iter: 16'd11,  lat: 12};

    rst = 1'b1;
    data_in = 16'd0;
    in_valid = 1'b0; abort = 1'b0; res_ack = 1'b0;
    in_valid_w = 1'b0; abort_w = 1'b0; res_ack_w = 1'b0;
    #1;
    check("reset_outputs",
          {in_ready, ldA, ldB, clrP, ldP, decB, busy, done, err, iter_cnt, state_dbg}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", in_ready, 1);
    check("post_reset_iter", iter_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(vecs[i].p);
      run_op(vecs[i].a, vecs[i].b, vecs[i].iter, vecs[i].lat);
    end

    // abort in IDLE blocks acceptance
    @(negedge clk);
    data_in = 16'd77; in_valid = 1'b1; abort = 1'b1;
    #1;
    check("idle_abort_lda", ldA, 0);
    check("idle_abort_ready", in_ready, 0);
    @(negedge clk);
    check("idle_abort_state", state_dbg, 0);
    in_valid = 1'b0; abort = 1'b0;

    // abort on the third ADD cycle of B=6
    @(negedge clk);
    data_in = 16'd4; in_valid = 1'b1;
    @(negedge clk);
    data_in = 16'd6;
    for (k = 1; k <= 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k < 3) check("abort_pre_ldp", ldP, 1);
    end
    abort = 1'b1;
    #1;
    check("abort_strobes", {ldA, ldB, clrP, ldP, decB}, 0);
    @(negedge clk);
    check("abort_state", state_dbg, 0);
    check("abort_iter", iter_cnt, 2);
    check("abort_busy", busy, 0);
    abort = 1'b0;
    #1;
    check("abort_ready", in_ready, 1);
    exp_q.push_back(16'd6);
    run_op(16'd2, 16'd3, 16'd3, 4);

    // asynchronous reset in the middle of ADD
    @(negedge clk);
    data_in = 16'd8; in_valid = 1'b1;
    @(negedge clk);
    data_in = 16'd20;
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs",
          {in_ready, ldA, ldB, clrP, ldP, decB, busy, done, err, iter_cnt, state_dbg}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", in_ready, 1);
    exp_q.push_back(16'd12);
    run_op(16'd3, 16'd4, 16'd4, 5);

    // watchdog on the MAX_ITER=4 instance
    @(negedge clk);
    data_in = 16'd5; in_valid_w = 1'b1;
    @(negedge clk);
    data_in = 16'd10;
    n_ldp = 0;
    seen  = 0;
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      in_valid_w = 1'b0;
      if (err_w) begin
        seen = 1;
        break;
      end
      if (ldP_w) n_ldp++;
    end
    check("wd_err_seen", seen, 1);
    check("wd_latency", k, 5);
    check("wd_ldp_count", n_ldp, 4);
    check("wd_iter", iter_cnt_w, 4);
    check("wd_done", done_w, 0);
    repeat (3) begin
      @(negedge clk);
      check("wd_err_hold", err_w, 1);
    end
    res_ack_w = 1'b1;
    @(negedge clk);
    res_ack_w = 1'b0;
    check("wd_err_clear", err_w, 0);
    check("wd_ready", in_ready_w, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
